traffic_timer: RTL and testbench
================================

# traffic_timer

Interval timer that serves the traffic-light controller's timer interface: it receives the controller's START_TIMER request and returns the T_YELLOW and T_HOLD expiry flags. A prescaler divides clk down to a timing tick. A tick counter, restarted by START_TIMER, measures the yellow interval and the minimum green-hold interval. It sits beside the controller in the intersection top level, one instance per controller.

## Interface
- TICK_DIV, 4: clk cycles per timing tick; legal range ≥1; 1 means every cycle is a tick.
- YELLOW_TICKS, 2: ticks from restart until T_YELLOW asserts; legal range 1..2^CNT_W−1.
- HOLD_TICKS, 5: ticks from restart until T_HOLD asserts; legal range 1..2^CNT_W−1.
- CNT_W, 8: tick counter width.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- START_TIMER  in  1  restart request, sampled every rising edge.
- T_YELLOW  out  1  registered; yellow interval elapsed since the last restart.
- T_HOLD  out  1  registered; hold interval elapsed since the last restart.

## Operation
- State machine (enum in the package), two states:
  - RUN: prescaler and tick counter advance.
  - DONE: tick counter saturated; both flags high; prescaler idle.
- Reset (reset=0): state=RUN, prescaler=0, count=0, T_YELLOW=0, T_HOLD=0.
  - On release, the timer runs immediately, so the controller's initial express-green state receives T_HOLD without an explicit START.
- START_TIMER=1 at an edge, from either state: state=RUN, prescaler=0, count=0, T_YELLOW=0, T_HOLD=0.
- RUN, no START:
  - Prescaler counts 0..TICK_DIV−1 and produces a tick when it wraps.
  - On a tick, count increments.
  - T_YELLOW is set when the new count equals YELLOW_TICKS.
  - T_HOLD is set when the new count equals HOLD_TICKS.
  - When the new count equals max(YELLOW_TICKS, HOLD_TICKS), state goes to DONE.
- DONE: all state holds. Flags stay high until the next START or reset.
- Flags are sticky levels, not pulses. Once set, a flag stays set until restart.
- Arithmetic:
  - count never exceeds max(YELLOW_TICKS, HOLD_TICKS), so there is no wrap.
  - Prescaler width is $clog2(TICK_DIV), with a minimum of 1.
- Simultaneous events: START on the same edge as a tick, flag set or DONE entry → restart wins; no flag rises.
- START held high continuously → the timer is held at zero and flags never assert.

## Timing
- Restart edge E (START sampled high): flags are 0 from the cycle after E.
- T_YELLOW is high from the cycle after edge E + YELLOW_TICKS·TICK_DIV.
- T_HOLD is high from the cycle after edge E + HOLD_TICKS·TICK_DIV.
- After reset release, the first rising edge counts as edge E+1, so the same latencies apply.
- Reset assertion clears outputs combinationally through the flop resets, with no clock needed.
- No combinational path from START_TIMER to any output.

## Configuration
- TRAFFIC_TIMER_CFG_EN defined: adds two input ports, yellow_ticks and hold_ticks [CNT_W-1:0].
  - Both are latched into internal registers on every START edge and on reset release (reset loads YELLOW_TICKS / HOLD_TICKS).
  - The latched values replace the parameters for the current interval.
  - A latched value of 0 is treated as 1.
  - Changing the inputs mid-interval has no effect until the next START.
- TRAFFIC_TIMER_CFG_EN undefined: no extra ports; durations are fixed by the parameters.

## Structure
- traffic_pkg holds:
  - the timer state enum (RUN, DONE);
  - default constants for TICK_DIV, YELLOW_TICKS, HOLD_TICKS and CNT_W;
  - a max() constant function.
- One sub-module, tick_prescaler:
  - inputs clk, reset, clr;
  - output tick, one cycle wide.
  - clr has priority over counting.

## Test plan
- Defaults (TICK_DIV=4, YELLOW=2, HOLD=5): release reset with no START → T_YELLOW rises after the 8th edge and T_HOLD after the 20th edge; both stay 1 for 50 more cycles.
- One-cycle START pulse at edge 30 while in DONE → both flags 0 after edge 30; T_YELLOW returns after edge 38 and T_HOLD after edge 50.
- START high for 40 continuous cycles → T_YELLOW=T_HOLD=0 throughout; after START drops at edge n, T_YELLOW rises after edge n+8.
- START asserted exactly on edge E+20 (the edge where T_HOLD would set) → T_HOLD stays 0, T_YELLOW clears, and T_HOLD rises after edge E+40.
- reset driven low mid-interval (count=3) between clock edges → outputs 0 immediately; after release, timing restarts from zero.
- With TRAFFIC_TIMER_CFG_EN, yellow_ticks=0 and hold_ticks=3 latched at START edge E → T_YELLOW rises after edge E+4 and T_HOLD after edge E+12. Changing hold_ticks to 10 mid-interval → no change.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types and defaults for the traffic-light interval
//               timer: timer state enum, default timing constants, and a
//               max() constant function used to size the DONE threshold.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // RUN  : prescaler and tick counter advance
    // DONE : tick counter saturated, both flags high, prescaler idle
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DONE = 1'b1
    } timer_state_e;

    localparam int DEF_TICK_DIV     = 4;
    localparam int DEF_YELLOW_TICKS = 2;
    localparam int DEF_HOLD_TICKS   = 5;
    localparam int DEF_CNT_W        = 8;

    function automatic int unsigned max_val(input int unsigned a,
                                            input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Divides clk down to a one-cycle timing tick every TICK_DIV
//               cycles. clr has priority and returns the divider to zero.
// Ports       : clk   - system clock
//               reset - asynchronous active-low reset
//               clr   - synchronous clear (priority over counting)
//               tick  - high for one cycle when the divider wraps
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick marks the cycle whose rising edge wraps the divider.
    assign tick = (cnt_q == LAST);

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/traffic_timer.sv
`default_nettype none
// ============================================================================
// Module      : traffic_timer
// Description : Interval timer for the traffic-light controller. A restart
//               (START_TIMER) clears a tick counter; sticky flags T_YELLOW
//               and T_HOLD rise once YELLOW_TICKS / HOLD_TICKS ticks have
//               elapsed. The counter saturates in DONE.
// Ports       : clk          - system clock
//               reset        - asynchronous active-low reset
//               START_TIMER  - restart request
//               T_YELLOW     - registered sticky yellow-elapsed flag
//               T_HOLD       - registered sticky hold-elapsed flag
//               yellow_ticks - (TRAFFIC_TIMER_CFG_EN) runtime yellow ticks
//               hold_ticks   - (TRAFFIC_TIMER_CFG_EN) runtime hold ticks
// Macro       : TRAFFIC_TIMER_CFG_EN - adds runtime-configurable durations,
//               latched on every restart; a latched 0 behaves as 1.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             START_TIMER,
`ifdef TRAFFIC_TIMER_CFG_EN
    input  logic [CNT_W-1:0] yellow_ticks,
    input  logic [CNT_W-1:0] hold_ticks,
`endif
    output logic             T_YELLOW,
    output logic             T_HOLD
);

    timer_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             t_yellow_q, t_yellow_d;
    logic             t_hold_q, t_hold_d;
    logic             tick;
    logic [CNT_W-1:0] yellow_lim;
    logic [CNT_W-1:0] hold_lim;
    logic [CNT_W-1:0] done_lim;
    logic [CNT_W-1:0] count_inc;

`ifdef TRAFFIC_TIMER_CFG_EN
    logic [CNT_W-1:0] yellow_lim_q, yellow_lim_d;
    logic [CNT_W-1:0] hold_lim_q, hold_lim_d;

    // Limits are captured only at restart so mid-interval input changes
    // cannot disturb the running interval. Zero is promoted to one.
    always_comb begin
        yellow_lim_d = yellow_lim_q;
        hold_lim_d   = hold_lim_q;
        if (START_TIMER) begin
            yellow_lim_d = (yellow_ticks == '0) ? CNT_W'(1) : yellow_ticks;
            hold_lim_d   = (hold_ticks   == '0) ? CNT_W'(1) : hold_ticks;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            yellow_lim_q <= CNT_W'(YELLOW_TICKS);
            hold_lim_q   <= CNT_W'(HOLD_TICKS);
        end else begin
            yellow_lim_q <= yellow_lim_d;
            hold_lim_q   <= hold_lim_d;
        end
    end

    assign yellow_lim = yellow_lim_q;
    assign hold_lim   = hold_lim_q;
    assign done_lim   = (yellow_lim_q > hold_lim_q) ? yellow_lim_q : hold_lim_q;
`else
    assign yellow_lim = CNT_W'(YELLOW_TICKS);
    assign hold_lim   = CNT_W'(HOLD_TICKS);
    assign done_lim   = CNT_W'(max_val(YELLOW_TICKS, HOLD_TICKS));
`endif

    // Holding the divider clear in DONE keeps it idle and guarantees a
    // restart always begins a full TICK_DIV period.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (START_TIMER || (state_q == DONE)),
        .tick  (tick)
    );

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        t_yellow_d = t_yellow_q;
        t_hold_d   = t_hold_q;
        if (START_TIMER) begin
            // Restart wins over any coincident tick, flag set or DONE entry.
            state_d    = RUN;
            count_d    = '0;
            t_yellow_d = 1'b0;
            t_hold_d   = 1'b0;
        end else if ((state_q == RUN) && tick) begin
            count_d = count_inc;
            if (count_inc == yellow_lim) t_yellow_d = 1'b1;
            if (count_inc == hold_lim)   t_hold_d   = 1'b1;
            if (count_inc == done_lim)   state_d    = DONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            count_q    <= '0;
            t_yellow_q <= 1'b0;
            t_hold_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            t_yellow_q <= t_yellow_d;
            t_hold_q   <= t_hold_d;
        end
    end

    assign T_YELLOW = t_yellow_q;
    assign T_HOLD   = t_hold_q;

endmodule : traffic_timer
`default_nettype wire

// File: tb/tb_traffic_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_timer
// Description : Self-checking bench for traffic_timer (default build).
//               A reference model tracks clk edges elapsed since the last
//               restart and derives each flag as elapsed >= ticks*TICK_DIV.
//               Directed scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_timer;

    localparam int TD = 4;
    localparam int YT = 2;
    localparam int HT = 5;

    logic clk;
    logic reset;
    logic START_TIMER;
    logic T_YELLOW;
    logic T_HOLD;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: edges since last restart (saturating).
    int elapsed = 0;

    traffic_timer #(
        .TICK_DIV     (TD),
        .YELLOW_TICKS (YT),
        .HOLD_TICKS   (HT),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .START_TIMER (START_TIMER),
        .T_YELLOW    (T_YELLOW),
        .T_HOLD      (T_HOLD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            elapsed = 0;
        end else if (START_TIMER) begin
            elapsed = 0;
        end else if (elapsed < 10000) begin
            elapsed = elapsed + 1;
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("model_yellow", T_YELLOW, (elapsed >= YT * TD) ? 1'b1 : 1'b0);
        check("model_hold",   T_HOLD,   (elapsed >= HT * TD) ? 1'b1 : 1'b0);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    logic seen_flag;

    initial begin
        reset       = 1'b0;
        START_TIMER = 1'b0;
        step(3);
        check("reset_yellow", T_YELLOW, 1'b0);
        check("reset_hold",   T_HOLD,   1'b0);

        // Release with no START: edge 1 is the next rising edge.
        reset = 1'b1;
        step(7);  check("rel_e7_yellow",  T_YELLOW, 1'b0);
        step(1);  check("rel_e8_yellow",  T_YELLOW, 1'b1);
        step(11); check("rel_e19_hold",   T_HOLD,   1'b0);
        step(1);  check("rel_e20_hold",   T_HOLD,   1'b1);

        // One-cycle START pulse at edge 30 while in DONE.
        step(9);
        check("done_e29_yellow", T_YELLOW, 1'b1);
        START_TIMER = 1'b1;
        step(1);
        START_TIMER = 1'b0;
        check("pulse_e30_yellow", T_YELLOW, 1'b0);
        check("pulse_e30_hold",   T_HOLD,   1'b0);
        step(7);  check("pulse_e37_yellow", T_YELLOW, 1'b0);
        step(1);  check("pulse_e38_yellow", T_YELLOW, 1'b1);
        step(11); check("pulse_e49_hold",   T_HOLD,   1'b0);
        step(1);  check("pulse_e50_hold",   T_HOLD,   1'b1);

        // Flags stay high for a long stretch in DONE.
        step(50);
        check("sticky_yellow", T_YELLOW, 1'b1);
        check("sticky_hold",   T_HOLD,   1'b1);

        // START held for 40 cycles keeps the timer at zero.
        START_TIMER = 1'b1;
        seen_flag   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (T_YELLOW || T_HOLD) seen_flag = 1'b1;
        end
        START_TIMER = 1'b0;
        check("held_no_flags", seen_flag, 1'b0);
        step(7);  check("held_m7_yellow", T_YELLOW, 1'b0);
        step(1);  check("held_m8_yellow", T_YELLOW, 1'b1);

        // START exactly on the edge where T_HOLD would set (E = last START).
        step(11);
        check("coinc_e19_hold", T_HOLD, 1'b0);
        START_TIMER = 1'b1;
        step(1);
        START_TIMER = 1'b0;
        check("coinc_e20_hold",   T_HOLD,   1'b0);
        check("coinc_e20_yellow", T_YELLOW, 1'b0);
        step(19); check("coinc_e39_hold", T_HOLD, 1'b0);
        step(1);  check("coinc_e40_hold", T_HOLD, 1'b1);

        // Asynchronous reset mid-interval at count = 3.
        START_TIMER = 1'b1;
        step(1);
        START_TIMER = 1'b0;
        step(13);
        check("pre_rst_yellow", T_YELLOW, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("async_rst_yellow", T_YELLOW, 1'b0);
        check("async_rst_hold",   T_HOLD,   1'b0);
        step(2);
        reset = 1'b1;
        step(7);  check("rerel_e7_yellow", T_YELLOW, 1'b0);
        step(1);  check("rerel_e8_yellow", T_YELLOW, 1'b1);
        step(11); check("rerel_e19_hold",  T_HOLD,   1'b0);
        step(1);  check("rerel_e20_hold",  T_HOLD,   1'b1);

        step(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_traffic_timer
`default_nettype wire
